// File: rtl/zxw_display_arbiter.sv
// Round-robin arbiter that shares one registered display pattern among four requesters.
// Each grant is held for at least MIN_HOLD cycles once Done is seen, and is revoked after MAX_HOLD cycles.
module zxw_display_arbiter #(
    parameter int DW       = 8,
    parameter int MIN_HOLD = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [3:0]      Req,
    input  logic [3:0]      Done,
    input  logic [4*DW-1:0] Data_in,
    output logic [3:0]      Grant,
    output logic [DW-1:0]   Display_out,
    output logic            Busy,
    output logic            Timeout_out
);

    localparam int HW = $clog2(MAX_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      gidx_q, gidx_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            done_pend_q, done_pend_d;
    logic [3:0]      grant_q, grant_d;
    logic [DW-1:0]   display_q, display_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;

    logic            sel_found_s;
    logic [1:0]      sel_idx_s;
    logic            done_seen_s;

    // First requesting index at or after ptr, wrapping modulo 4; bit 2 flags that one was found.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + k[1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    assign {sel_found_s, sel_idx_s} = rr_pick(Req, ptr_q);
    assign done_seen_s = Done[gidx_q] | done_pend_q;

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        hold_cnt_d  = hold_cnt_q;
        done_pend_d = done_pend_q;
        grant_d     = grant_q;
        display_d   = display_q;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_found_s) begin
                    state_d     = ST_GRANT;
                    gidx_d      = sel_idx_s;
                    grant_d     = 4'b0001 << sel_idx_s;
                    hold_cnt_d  = '0;
                    done_pend_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                display_d   = Data_in[int'(gidx_q)*DW +: DW];
                hold_cnt_d  = hold_cnt_q + {{(HW-1){1'b0}}, 1'b1};
                done_pend_d = done_seen_s;
                // Priority: requester withdrawal, then honoured Done, then forced timeout.
                if (!Req[gidx_q]) begin
                    state_d = ST_RELEASE;
                end else if (done_seen_s && (hold_cnt_q >= HW'(MIN_HOLD - 1))) begin
                    state_d = ST_RELEASE;
                end else if (hold_cnt_q == HW'(MAX_HOLD - 1)) begin
                    state_d   = ST_RELEASE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_GRANT;
                end
                if (state_d == ST_RELEASE) begin
                    grant_d    = 4'b0000;
                    ptr_d      = gidx_q + 2'd1;
                    hold_cnt_d = hold_cnt_q;
                end else begin
                    grant_d = grant_q;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
            end
        endcase
        busy_d = (state_d == ST_GRANT);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd0;
            gidx_q      <= 2'd0;
            hold_cnt_q  <= '0;
            done_pend_q <= 1'b0;
            grant_q     <= 4'b0000;
            display_q   <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            hold_cnt_q  <= hold_cnt_d;
            done_pend_q <= done_pend_d;
            grant_q     <= grant_d;
            display_q   <= display_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
        end
    end

    assign Grant       = grant_q;
    assign Display_out = display_q;
    assign Busy        = busy_q;
    assign Timeout_out = timeout_q;

endmodule

// File: tb/tb_zxw_display_arbiter.sv
// Directed bench for zxw_display_arbiter: round-robin order, dwell limits, timeout and async reset.
module tb_zxw_display_arbiter;

    localparam int DW = 8;

    logic            Clock;
    logic            Reset;
    logic [3:0]      Req;
    logic [3:0]      Done;
    logic [4*DW-1:0] Data_in;
    logic [3:0]      Grant;
    logic [DW-1:0]   Display_out;
    logic            Busy;
    logic            Timeout_out;

    int checks   = 0;
    int failures = 0;

    zxw_display_arbiter #(.DW(DW), .MIN_HOLD(4), .MAX_HOLD(16)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Req        (Req),
        .Done       (Done),
        .Data_in    (Data_in),
        .Grant      (Grant),
        .Display_out(Display_out),
        .Busy       (Busy),
        .Timeout_out(Timeout_out)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset   = 1'b1;
        Req     = 4'b0000;
        Done    = 4'b0000;
        Data_in = {8'h44, 8'h22, 8'h11, 8'h5A};
        step();
        step();
        chk("rst_grant", 32'(Grant), 32'h0);
        chk("rst_disp", 32'(Display_out), 32'h0);
        chk("rst_busy", 32'(Busy), 32'h0);
        chk("rst_tmo", 32'(Timeout_out), 32'h0);
        Reset = 1'b0;

        // Simultaneous requests 1 and 2 from reset: 1 wins, Done releases after 4 cycles.
        Req = 4'b0110;
        step();
        chk("t2_grant1", 32'(Grant), 32'h2);
        chk("t2_busy", 32'(Busy), 32'h1);
        chk("t2_disp_old", 32'(Display_out), 32'h0);
        Done = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_hold", 32'(Grant), 32'h2);
        end
        chk("t2_disp_fwd", 32'(Display_out), 32'h11);
        step();
        chk("t2_release", 32'(Grant), 32'h0);
        chk("t2_rel_busy", 32'(Busy), 32'h0);
        chk("t2_rel_tmo", 32'(Timeout_out), 32'h0);
        chk("t2_rel_disp", 32'(Display_out), 32'h11);
        Done = 4'b0000;
        step();
        chk("t2_dead", 32'(Grant), 32'h0);
        step();
        chk("t2_grant2", 32'(Grant), 32'h4);

        // Requester 2 alone without Done: revoked after 16 cycles with one timeout pulse.
        Req = 4'b0100;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("t4_hold", 32'(Grant), 32'h4);
            chk("t4_tmo_low", 32'(Timeout_out), 32'h0);
        end
        step();
        chk("t4_revoke", 32'(Grant), 32'h0);
        chk("t4_tmo_pulse", 32'(Timeout_out), 32'h1);
        step();
        chk("t4_tmo_end", 32'(Timeout_out), 32'h0);
        chk("t4_dead", 32'(Grant), 32'h0);
        step();
        chk("t4_regrant", 32'(Grant), 32'h4);

        // Drop request: immediate release; then requester 3 withdraws at hold 1.
        Req = 4'b0000;
        step();
        chk("t5_drop2", 32'(Grant), 32'h0);
        step();
        Req = 4'b1000;
        step();
        chk("t5_grant3", 32'(Grant), 32'h8);
        step();
        chk("t5_hold1", 32'(Grant), 32'h8);
        Req = 4'b0000;
        step();
        chk("t5_release", 32'(Grant), 32'h0);
        chk("t5_tmo", 32'(Timeout_out), 32'h0);
        chk("t5_busy", 32'(Busy), 32'h0);

        // Done[0] from the first grant cycle: granted for exactly 4 cycles.
        Req  = 4'b0001;
        Done = 4'b0001;
        step();
        chk("t3_dead", 32'(Grant), 32'h0);
        step();
        chk("t3_grant0", 32'(Grant), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold", 32'(Grant), 32'h1);
        end
        step();
        chk("t3_release", 32'(Grant), 32'h0);
        Done = 4'b0000;

        // Pattern changes while requester 1 is granted follow one cycle later.
        Req = 4'b0010;
        Data_in[DW +: DW] = 8'hA5;
        step();
        step();
        chk("t6_grant1", 32'(Grant), 32'h2);
        step();
        chk("t6_disp_a5", 32'(Display_out), 32'hA5);
        Data_in[DW +: DW] = 8'h3C;
        step();
        chk("t6_disp_3c", 32'(Display_out), 32'h3C);
        Req = 4'b0000;
        step();
        chk("t6_release", 32'(Grant), 32'h0);
        chk("t6_keep", 32'(Display_out), 32'h3C);
        Data_in[DW +: DW] = 8'h77;
        step();
        chk("t6_keep2", 32'(Display_out), 32'h3C);

        // Asynchronous reset in the middle of a grant.
        Req = 4'b0001;
        step();
        chk("t1_grant0", 32'(Grant), 32'h1);
        step();
        chk("t1_disp", 32'(Display_out), 32'h5A);
        #2;
        Reset = 1'b1;
        #1;
        chk("t1_async_grant", 32'(Grant), 32'h0);
        chk("t1_async_disp", 32'(Display_out), 32'h0);
        chk("t1_async_busy", 32'(Busy), 32'h0);
        step();
        Reset = 1'b0;
        step();
        chk("t1_after_rst", 32'(Grant), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
